// File: rtl/mm2s_ram_reader_if.sv
// AXI4 read-address / read-data channels plus the AXI-Stream master channel
// of the memory-to-stream reader, bundled so the engine and its environment
// share one definition.
//   master : the read engine (drives AR, RREADY and the stream)
//   slave  : the memory / stream sink side
interface mm2s_ram_reader_if #(
    parameter int ADDR_WIDTH     = 32,
    parameter int AXI_ID_WIDTH   = 6,
    parameter int AXI_DATA_WIDTH = 32
);
    logic [AXI_ID_WIDTH-1:0]   M_AXI_arid;
    logic [ADDR_WIDTH-1:0]     M_AXI_araddr;
    logic [7:0]                M_AXI_arlen;
    logic [2:0]                M_AXI_arsize;
    logic [1:0]                M_AXI_arburst;
    logic [3:0]                M_AXI_arcache;
    logic [2:0]                M_AXI_arprot;
    logic                      M_AXI_aruser;
    logic                      M_AXI_arvalid;
    logic                      M_AXI_arready;
    logic [AXI_DATA_WIDTH-1:0] M_AXI_rdata;
    logic [1:0]                M_AXI_rresp;
    logic                      M_AXI_rlast;
    logic                      M_AXI_rvalid;
    logic                      M_AXI_rready;
    logic [AXI_DATA_WIDTH-1:0] M_AXIS_tdata;
    logic                      M_AXIS_tvalid;
    logic                      M_AXIS_tlast;
    logic                      M_AXIS_tready;

    modport master (
        output M_AXI_arid, M_AXI_araddr, M_AXI_arlen, M_AXI_arsize, M_AXI_arburst,
               M_AXI_arcache, M_AXI_arprot, M_AXI_aruser, M_AXI_arvalid, M_AXI_rready,
               M_AXIS_tdata, M_AXIS_tvalid, M_AXIS_tlast,
        input  M_AXI_arready, M_AXI_rdata, M_AXI_rresp, M_AXI_rlast, M_AXI_rvalid,
               M_AXIS_tready
    );

    modport slave (
        input  M_AXI_arid, M_AXI_araddr, M_AXI_arlen, M_AXI_arsize, M_AXI_arburst,
               M_AXI_arcache, M_AXI_arprot, M_AXI_aruser, M_AXI_arvalid, M_AXI_rready,
               M_AXIS_tdata, M_AXIS_tvalid, M_AXIS_tlast,
        output M_AXI_arready, M_AXI_rdata, M_AXI_rresp, M_AXI_rlast, M_AXI_rvalid,
               M_AXIS_tready
    );
endinterface

// File: rtl/mm2s_ram_reader.sv
// Memory-to-stream read engine. On start it fetches num_bursts fixed-length
// INCR bursts starting at an aligned base address and replays the data in
// order on an AXI-Stream master through an internal first-word-fall-through
// FIFO. AR issue is credit-limited so R data never needs back-pressure.
// Ports:
//   aclk, aresetn  : clock, synchronous active-low reset
//   start          : single-cycle request, honoured only when idle
//   base_addr      : first byte address (low alignment bits ignored)
//   num_bursts     : burst count, sampled with start
//   busy/done/error: status (busy level, done pulse, sticky RRESP error)
//   m              : AR/R master channels and the AXI-Stream master
module mm2s_ram_reader #(
    parameter int ADDR_WIDTH     = 32,
    parameter int AXI_ID_WIDTH   = 6,
    parameter int AXI_DATA_WIDTH = 32,
    parameter int BURST_LEN      = 16,
    parameter int FIFO_DEPTH     = 64
) (
    input  logic                  aclk,
    input  logic                  aresetn,
    input  logic                  start,
    input  logic [ADDR_WIDTH-1:0] base_addr,
    input  logic [15:0]           num_bursts,
    output logic                  busy,
    output logic                  done,
    output logic                  error,
    mm2s_ram_reader_if.master     m
);
    localparam int BEAT_BYTES  = AXI_DATA_WIDTH / 8;
    localparam int BURST_BYTES = BURST_LEN * BEAT_BYTES;
    localparam int ALIGN_LG    = $clog2(BURST_BYTES);
    localparam int FIFO_AW     = $clog2(FIFO_DEPTH);
    localparam int CW          = FIFO_AW + 1;   // holds 0..FIFO_DEPTH
    localparam int SW          = FIFO_AW + 3;   // headroom for the credit sum
    localparam int BEAT_W      = 16 + $clog2(BURST_LEN);
    localparam logic [ADDR_WIDTH-1:0] ALIGN_MASK = {ADDR_WIDTH{1'b1}} << ALIGN_LG;

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN} state_t;

    state_t                    r_state;
    logic                      r_busy, r_done, r_error;
    logic                      r_arvalid, r_rready;
    logic [ADDR_WIDTH-1:0]     r_araddr;        // address of the next burst to issue
    logic [15:0]               r_nbursts, r_ar_issued;
    logic [BEAT_W-1:0]         r_total, r_tx_cnt;
    logic [CW-1:0]             r_outst, r_fifo_cnt;
    logic                      r_pipe_vld;
    logic [AXI_DATA_WIDTH-1:0] r_pipe_data;
    logic [FIFO_AW-1:0]        r_wr_ptr, r_rd_ptr;
    logic [AXI_DATA_WIDTH-1:0] r_mem [FIFO_DEPTH];

    logic w_ar_hs, w_r_hs, w_t_hs, w_tvalid, w_last_beat, w_ar_last, w_credit_ok;

    assign w_tvalid    = (r_fifo_cnt != '0);
    assign w_ar_hs     = r_arvalid & m.M_AXI_arready;
    assign w_r_hs      = r_rready & m.M_AXI_rvalid;
    assign w_t_hs      = w_tvalid & m.M_AXIS_tready;
    assign w_last_beat = (r_tx_cnt == r_total - 1'b1);
    assign w_ar_last   = (r_ar_issued == r_nbursts - 16'd1);

    // Room for one more burst. The beat sitting in the R input register and a
    // burst being accepted this cycle are both counted, so the check is safe
    // even when arvalid stays high across consecutive handshakes.
    assign w_credit_ok = (SW'(r_fifo_cnt) + SW'(r_pipe_vld) + SW'(r_outst)
                          + (w_ar_hs ? SW'(BURST_LEN) : SW'(0)) + SW'(BURST_LEN))
                         <= SW'(FIFO_DEPTH);

    assign m.M_AXI_arid    = '0;
    assign m.M_AXI_araddr  = r_araddr;
    assign m.M_AXI_arlen   = 8'(BURST_LEN - 1);
    assign m.M_AXI_arsize  = 3'($clog2(BEAT_BYTES));
    assign m.M_AXI_arburst = 2'b01;
    assign m.M_AXI_arcache = 4'b0011;
    assign m.M_AXI_arprot  = 3'b000;
    assign m.M_AXI_aruser  = 1'b0;
    assign m.M_AXI_arvalid = r_arvalid;
    assign m.M_AXI_rready  = r_rready;
    assign m.M_AXIS_tdata  = r_mem[r_rd_ptr];
    assign m.M_AXIS_tvalid = w_tvalid;
    assign m.M_AXIS_tlast  = w_tvalid & w_last_beat;

    assign busy  = r_busy;
    assign done  = r_done;
    assign error = r_error;

    // FIFO storage; pointers live in the control block so reset flushes it.
    always_ff @(posedge aclk) begin
        if (r_pipe_vld) r_mem[r_wr_ptr] <= r_pipe_data;
    end

    always_ff @(posedge aclk) begin
        if (!aresetn) begin
            r_state     <= S_IDLE;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
            r_error     <= 1'b0;
            r_arvalid   <= 1'b0;
            r_rready    <= 1'b0;
            r_araddr    <= '0;
            r_nbursts   <= '0;
            r_ar_issued <= '0;
            r_total     <= '0;
            r_tx_cnt    <= '0;
            r_outst     <= '0;
            r_fifo_cnt  <= '0;
            r_pipe_vld  <= 1'b0;
            r_pipe_data <= '0;
            r_wr_ptr    <= '0;
            r_rd_ptr    <= '0;
        end else begin
            r_done   <= 1'b0;
            r_rready <= 1'b1;

            // R beats are registered once before entering the FIFO.
            r_pipe_vld <= w_r_hs;
            if (w_r_hs) r_pipe_data <= m.M_AXI_rdata;
            if (w_r_hs && m.M_AXI_rresp != 2'b00) r_error <= 1'b1;

            if (r_pipe_vld) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_t_hs) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
                r_tx_cnt <= r_tx_cnt + 1'b1;
            end
            r_fifo_cnt <= r_fifo_cnt + CW'(r_pipe_vld) - CW'(w_t_hs);
            r_outst    <= r_outst + (w_ar_hs ? CW'(BURST_LEN) : CW'(0)) - CW'(w_r_hs);

            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_error <= 1'b0;
                        if (num_bursts == 16'd0) begin
                            r_done <= 1'b1;
                        end else begin
                            // An empty FIFO always has room for the first burst.
                            r_state     <= S_RUN;
                            r_busy      <= 1'b1;
                            r_nbursts   <= num_bursts;
                            r_total     <= BEAT_W'(num_bursts) * BEAT_W'(BURST_LEN);
                            r_ar_issued <= '0;
                            r_tx_cnt    <= '0;
                            r_araddr    <= base_addr & ALIGN_MASK;
                            r_arvalid   <= 1'b1;
                        end
                    end
                end
                S_RUN: begin
                    if (w_ar_hs) begin
                        r_ar_issued <= r_ar_issued + 16'd1;
                        r_araddr    <= r_araddr + ADDR_WIDTH'(BURST_BYTES);
                        if (w_ar_last) begin
                            r_arvalid <= 1'b0;
                            r_state   <= S_DRAIN;
                        end else begin
                            r_arvalid <= w_credit_ok;
                        end
                    end else if (!r_arvalid) begin
                        r_arvalid <= w_credit_ok;
                    end
                end
                S_DRAIN: begin
                    // The final stream beat implies every R beat has arrived
                    // and the FIFO empties on this edge.
                    if (w_t_hs && w_last_beat) begin
                        r_done  <= 1'b1;
                        r_busy  <= 1'b0;
                        r_state <= S_IDLE;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_mm2s_ram_reader.sv
module tb_mm2s_ram_reader;
    localparam int BL    = 16;
    localparam int DEPTH = 64;

    logic        aclk = 1'b0;
    logic        aresetn = 1'b0;
    logic        start = 1'b0;
    logic [31:0] base_addr = '0;
    logic [15:0] num_bursts = '0;
    logic        busy, done, error;

    mm2s_ram_reader_if #(.ADDR_WIDTH(32), .AXI_ID_WIDTH(6), .AXI_DATA_WIDTH(32)) bus ();

    mm2s_ram_reader #(.ADDR_WIDTH(32), .AXI_ID_WIDTH(6), .AXI_DATA_WIDTH(32),
                      .BURST_LEN(BL), .FIFO_DEPTH(DEPTH)) dut (
        .aclk(aclk), .aresetn(aresetn), .start(start), .base_addr(base_addr),
        .num_bursts(num_bursts), .busy(busy), .done(done), .error(error), .m(bus));

    always #5 aclk = ~aclk;

    typedef struct { logic [31:0] addr; bit err; bit last; } beat_t;
    typedef struct { logic [31:0] data; bit last; } st_t;
    typedef struct { logic [31:0] base; int nb; int p_ar; int p_r; int p_t;
                     int eburst; logic exp_err; } vec_t;

    logic [31:0] exp_ar[$];
    st_t         exp_st[$];
    beat_t       pend[$];

    int checks = 0, fails = 0;
    int ar_cnt = 0, st_cnt = 0, done_cnt = 0, credit_viol = 0;
    int p_ar = 100, p_r = 100, p_t = 100, err_burst = -1;
    bit force_t0 = 1'b0;

    function automatic logic [31:0] memw(input logic [31:0] a);
        return (a >> 2) ^ 32'h0400_0000;
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    // Memory slave, stream sink and scoreboard. Inputs change at the negedge;
    // DUT outputs are register-driven, so the handshakes seen here are the
    // ones the next rising edge will take.
    initial begin : bus_model
        bit ar_hs, r_hs, t_hs;
        beat_t bt;
        st_t s;
        logic [31:0] ea;
        bus.M_AXI_arready = 1'b0; bus.M_AXI_rvalid = 1'b0; bus.M_AXI_rdata = '0;
        bus.M_AXI_rresp = 2'b00; bus.M_AXI_rlast = 1'b0; bus.M_AXIS_tready = 1'b0;
        forever begin
            @(negedge aclk);
            if (!aresetn) begin
                bus.M_AXI_arready = 1'b0; bus.M_AXI_rvalid = 1'b0; bus.M_AXIS_tready = 1'b0;
            end else begin
                bus.M_AXI_arready = ($urandom_range(99) < p_ar);
                ar_hs = bus.M_AXI_arvalid && bus.M_AXI_arready;
                if (!(bus.M_AXI_rvalid && !bus.M_AXI_rready)) begin
                    if (pend.size() > 0 && $urandom_range(99) < p_r) begin
                        bus.M_AXI_rvalid = 1'b1;
                        bus.M_AXI_rdata  = memw(pend[0].addr);
                        bus.M_AXI_rresp  = pend[0].err ? 2'b10 : 2'b00;
                        bus.M_AXI_rlast  = pend[0].last;
                    end else begin
                        bus.M_AXI_rvalid = 1'b0;
                    end
                end
                r_hs = bus.M_AXI_rvalid && bus.M_AXI_rready;
                if (r_hs) pend.delete(0);
                bus.M_AXIS_tready = force_t0 ? 1'b0 : ($urandom_range(99) < p_t);
                t_hs = bus.M_AXIS_tvalid && bus.M_AXIS_tready;

                if (ar_hs) begin
                    if (exp_ar.size() == 0) begin
                        checks++; fails++;
                        $display("FAIL ar_unexpected actual=%0h required=none", bus.M_AXI_araddr);
                    end else begin
                        ea = exp_ar.pop_front();
                        chk("araddr", bus.M_AXI_araddr, ea);
                    end
                    chk("ar_fields", {bus.M_AXI_arid, bus.M_AXI_arlen, bus.M_AXI_arsize,
                        bus.M_AXI_arburst, bus.M_AXI_arcache, bus.M_AXI_arprot, bus.M_AXI_aruser},
                        {6'h0, 8'd15, 3'd2, 2'b01, 4'b0011, 3'b000, 1'b0});
                    for (int i = 0; i < BL; i++) begin
                        bt.addr = bus.M_AXI_araddr + 32'(4 * i);
                        bt.err  = (ar_cnt == err_burst) && (i == 4);
                        bt.last = (i == BL - 1);
                        pend.push_back(bt);
                    end
                    ar_cnt++;
                end
                if (t_hs) begin
                    if (exp_st.size() == 0) begin
                        checks++; fails++;
                        $display("FAIL st_unexpected actual=%0h required=none", bus.M_AXIS_tdata);
                    end else begin
                        s = exp_st.pop_front();
                        chk("tdata_tlast", {bus.M_AXIS_tdata, bus.M_AXIS_tlast}, {s.data, s.last});
                    end
                    st_cnt++;
                end
                if (done) done_cnt++;
                if (ar_cnt * BL - st_cnt > DEPTH) credit_viol++;
            end
        end
    end

    task automatic do_start(input logic [31:0] b, input int nb, input bit push,
                            output logic o_busy, output logic o_av,
                            output logic o_done, output logic o_err);
        logic [31:0] a;
        st_t s;
        @(negedge aclk);
        if (push) begin
            ar_cnt = 0; st_cnt = 0; credit_viol = 0;
            for (int k = 0; k < nb; k++) begin
                a = (b & 32'hFFFF_FFC0) + 32'(k * 64);
                exp_ar.push_back(a);
                for (int i = 0; i < BL; i++) begin
                    s.data = memw(a + 32'(4 * i));
                    s.last = (k == nb - 1) && (i == BL - 1);
                    exp_st.push_back(s);
                end
            end
        end
        start = 1'b1; base_addr = b; num_bursts = 16'(nb);
        @(posedge aclk); #1;
        o_busy = busy; o_av = bus.M_AXI_arvalid; o_done = done; o_err = error;
        @(negedge aclk);
        start = 1'b0;
    endtask

    task automatic end_xfer(input string tag, input int d0, input logic exp_err);
        int n = 0;
        while (done_cnt == d0 && n < 20000) begin
            @(posedge aclk);
            n++;
        end
        chk({tag, "_done_seen"}, 64'(done_cnt != d0), 1);
        repeat (20) @(posedge aclk);
        #1;
        chk({tag, "_done_once"}, done_cnt - d0, 1);
        chk({tag, "_busy_low"}, busy, 0);
        chk({tag, "_error"}, error, exp_err);
        chk({tag, "_ar_left"}, exp_ar.size(), 0);
        chk({tag, "_st_left"}, exp_st.size(), 0);
        chk({tag, "_credit"}, credit_viol, 0);
    endtask

    vec_t vt[5];
    logic b, av, dn, er;
    int d0, n;

    initial begin
        vt[0] = '{32'h1000_0000,   1, 100, 100, 100, -1, 1'b0};
        vt[1] = '{32'h1000_0013,   4, 100, 100, 100, -1, 1'b0};
        vt[2] = '{32'h2000_0100, 100,  60,  50,  50, -1, 1'b0};
        vt[3] = '{32'h3000_0000,   4,  80,  80,  80,  1, 1'b1};
        vt[4] = '{32'hFFFF_FFC0,   2, 100,  70, 100, -1, 1'b0};

        repeat (3) @(posedge aclk);
        #1;
        chk("reset_outputs", {bus.M_AXI_arvalid, bus.M_AXI_araddr, bus.M_AXI_rready,
            bus.M_AXIS_tvalid, bus.M_AXIS_tlast, busy, done, error}, 0);
        @(negedge aclk);
        aresetn = 1'b1;
        repeat (2) @(posedge aclk);
        #1;
        chk("rready_after_reset", bus.M_AXI_rready, 1);

        for (int i = 0; i < 5; i++) begin
            p_ar = vt[i].p_ar; p_r = vt[i].p_r; p_t = vt[i].p_t; err_burst = vt[i].eburst;
            d0 = done_cnt;
            do_start(vt[i].base, vt[i].nb, 1'b1, b, av, dn, er);
            chk($sformatf("vec%0d_start", i), {b, av, er}, 3'b110);
            end_xfer($sformatf("vec%0d", i), d0, vt[i].exp_err);
        end
        err_burst = -1; p_ar = 100; p_r = 100; p_t = 100;

        // A start while busy must not disturb the running transfer.
        d0 = done_cnt;
        do_start(32'h4000_0000, 3, 1'b1, b, av, dn, er);
        repeat (5) @(posedge aclk);
        do_start(32'h5000_0000, 7, 1'b0, b, av, dn, er);
        chk("busy_start_busy", b, 1);
        end_xfer("busy_start", d0, 1'b0);

        // Zero bursts: done next cycle, no AR, busy stays low.
        d0 = done_cnt;
        do_start(32'h8000_0000, 0, 1'b1, b, av, dn, er);
        chk("zero_start", {b, av, dn}, 3'b001);
        @(posedge aclk); #1;
        chk("zero_done_pulse", done, 0);
        repeat (10) @(posedge aclk);
        chk("zero_no_ar", ar_cnt, 0);
        chk("zero_done_once", done_cnt - d0, 1);

        // Stream stalled: credit stops AR issue after four bursts.
        force_t0 = 1'b1;
        d0 = done_cnt;
        do_start(32'h6000_0000, 8, 1'b1, b, av, dn, er);
        repeat (300) @(posedge aclk);
        #1;
        chk("stall_ar_cnt", ar_cnt, 4);
        chk("stall_arvalid", bus.M_AXI_arvalid, 0);
        chk("stall_rready", bus.M_AXI_rready, 1);
        force_t0 = 1'b0;
        end_xfer("stall", d0, 1'b0);
        chk("stall_total_ar", ar_cnt, 8);

        // Reset in the middle of burst 3, then a clean transfer.
        p_ar = 70; p_r = 70; p_t = 70;
        do_start(32'h7000_0000, 8, 1'b1, b, av, dn, er);
        n = 0;
        while (ar_cnt < 3 && n < 2000) begin
            @(posedge aclk);
            n++;
        end
        chk("midreset_reached", 64'(ar_cnt >= 3), 1);
        @(negedge aclk);
        aresetn = 1'b0;
        @(posedge aclk); #1;
        chk("midreset_outputs", {bus.M_AXI_arvalid, bus.M_AXI_araddr, bus.M_AXI_rready,
            bus.M_AXIS_tvalid, bus.M_AXIS_tlast, busy, done, error}, 0);
        repeat (2) @(posedge aclk);
        #1;
        exp_ar.delete(); exp_st.delete(); pend.delete();
        @(negedge aclk);
        aresetn = 1'b1;
        repeat (3) @(posedge aclk);
        d0 = done_cnt;
        do_start(32'h7100_0040, 2, 1'b1, b, av, dn, er);
        chk("post_reset_start", {b, av, er}, 3'b110);
        end_xfer("post_reset", d0, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
        $finish;
    end
endmodule
